sha256_msg_padder: RTL and testbench

//  Upstream stage of the SHA-256 hasher. Accepts a message as a stream of 32-bit words.

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_msg_padder_if.sv | 26 ++
 rtl/sha256_msg_padder.sv | 167 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constants, padder states
// and the round/initial-hash constants used by the compression core.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned BLOCK_W     = WORD_W * BLOCK_WORDS;
  localparam int unsigned LEN_WORDS   = 2;
  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    EMIT  = 2'd2,
    EXTRA = 2'd3
  } pad_state_e;

  localparam logic [WORD_W-1:0] INIT_H [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and padded-block output of the SHA-256 message padder.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               in_last;
  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               blk_first;
  logic               blk_final;
  logic               err_len;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_final, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_final, err_len
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects 32-bit words into 512-bit blocks, appends
// the 0x80000000 marker, zero fill and 64-bit bit length, spilling to an extra block when needed.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  sha256_msg_padder_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(BLOCK_WORDS + 1);
  localparam int unsigned LEN_HI = BLOCK_WORDS - LEN_WORDS;
  localparam int unsigned LEN_LO = BLOCK_WORDS - 1;
  localparam logic [IDX_W-1:0] LEN_SLOT   = IDX_W'(LEN_HI);
  localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] WCNT_MAX   = '1;

  pad_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0]  buf_q [BLOCK_WORDS];
  logic [WORD_W-1:0]  buf_d [BLOCK_WORDS];
  logic               err_q, err_d;
  logic               final_q, final_d;
  logic               pend_len_q, pend_len_d;
  logic               pend_pad_q, pend_pad_d;
  logic               msg_start_q, msg_start_d;
  logic               in_ready_q, in_ready_d;
  logic               blk_valid_q, blk_valid_d;
  logic               blk_first_q, blk_first_d;
  logic               blk_final_q, blk_final_d;
  logic [63:0]        len_c;
  logic [BLOCK_W-1:0] blk_data_c;

  // Next-state, buffer update and output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    buf_d       = buf_q;
    err_d       = err_q;
    final_d     = final_q;
    pend_len_d  = pend_len_q;
    pend_pad_d  = pend_pad_q;
    msg_start_d = msg_start_q;
    len_c       = 64'(wcnt_q) << 5;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          buf_d[idx_q[IDX_W-2:0]] = bus.in_data;
          idx_d = idx_q + IDX_W'(1);
          if (wcnt_q == WCNT_MAX) err_d  = 1'b1;
          else                    wcnt_d = wcnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = PAD;
          end else if (idx_d == IDX_FULL) begin
            state_d = EMIT;
            final_d = 1'b0;
          end
        end
      end
      PAD: begin
        // Marker lands at idx; every later slot is cleared so old words never leak
        for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
          if (IDX_W'(i) == idx_q)     buf_d[i] = PAD_WORD;
          else if (IDX_W'(i) > idx_q) buf_d[i] = '0;
        end
        if (idx_q < LEN_SLOT) begin
          buf_d[LEN_HI] = len_c[63:32];
          buf_d[LEN_LO] = len_c[31:0];
          final_d = 1'b1;
        end else if (idx_q < IDX_FULL) begin
          final_d    = 1'b0;
          pend_len_d = 1'b1;
        end else begin
          final_d    = 1'b0;
          pend_pad_d = 1'b1;
        end
        state_d = EMIT;
      end
      EMIT: begin
        if (bus.blk_ready) begin
          if (pend_len_q || pend_pad_q) begin
            state_d     = EXTRA;
            msg_start_d = 1'b0;
          end else if (final_q) begin
            state_d     = FILL;
            idx_d       = '0;
            wcnt_d      = '0;
            msg_start_d = 1'b1;
          end else begin
            state_d     = FILL;
            idx_d       = '0;
            msg_start_d = 1'b0;
          end
        end
      end
      EXTRA: begin
        for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_d[i] = '0;
        if (pend_pad_q) buf_d[0] = PAD_WORD;
        buf_d[LEN_HI] = len_c[63:32];
        buf_d[LEN_LO] = len_c[31:0];
        pend_len_d = 1'b0;
        pend_pad_d = 1'b0;
        final_d    = 1'b1;
        state_d    = EMIT;
      end
      default: state_d = FILL;
    endcase

    in_ready_d  = (state_d == FILL);
    blk_valid_d = (state_d == EMIT);
    blk_first_d = (state_d == EMIT) && msg_start_d;
    blk_final_d = (state_d == EMIT) && final_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      wcnt_q      <= '0;
      for (int i = 0; i < int'(BLOCK_WORDS); i++) buf_q[i] <= '0;
      err_q       <= 1'b0;
      final_q     <= 1'b0;
      pend_len_q  <= 1'b0;
      pend_pad_q  <= 1'b0;
      msg_start_q <= 1'b1;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_final_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      buf_q       <= buf_d;
      err_q       <= err_d;
      final_q     <= final_d;
      pend_len_q  <= pend_len_d;
      pend_pad_q  <= pend_pad_d;
      msg_start_q <= msg_start_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_final_q <= blk_final_d;
    end
  end

  // Word 0 occupies the most significant slice of the block
  always_comb begin
    blk_data_c = '0;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
      blk_data_c[BLOCK_W-1-WORD_W*i -: WORD_W] = buf_q[i];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_data_c;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_final = blk_final_q;
  assign bus.err_len   = err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a queue-based padding model.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam int unsigned TB_CNT_W = 6;

  typedef struct {
    logic [511:0] data;
    logic [511:0] mask;
    logic         first;
    logic         fin;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   stall_mode = 0;
  bit   mon_en = 1;

  logic [31:0] msg_q [$];
  exp_t        exp_q [$];

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.CNT_W(TB_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: message ++ marker ++ zeros to 14 mod 16 ++ 64-bit bit length
  task automatic push_expect(input bit mask_len);
    logic [31:0] w [$];
    logic [63:0] bits;
    int nb;
    exp_t e;
    w = msg_q;
    bits = 64'(msg_q.size()) * 64'd32;
    w.push_back(32'h8000_0000);
    while (w.size() % 16 != 14) w.push_back(32'h0);
    w.push_back(bits[63:32]);
    w.push_back(bits[31:0]);
    nb = w.size() / 16;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 16; j++) e.data[511-32*j -: 32] = w[16*b+j];
      e.mask  = '1;
      e.first = (b == 0);
      e.fin   = (b == nb - 1);
      if (mask_len && e.fin) e.mask[63:0] = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_msg(input bit with_last);
    int budget;
    for (int i = 0; i < msg_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = msg_q[i];
      bus.in_last  = with_last && (i == msg_q.size() - 1);
      budget = 0;
      while (!bus.in_ready && budget < 300) begin
        @(posedge clk); #1;
        budget++;
      end
      if (budget >= 300) chk("in_ready_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 600) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), '0);
    else                   chk("in_ready_after_final", bus.in_ready, 1'b1);
  endtask

  task automatic make_msg(input int n, input bit seq, input logic [31:0] base);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(seq ? base + 32'(i) : $urandom());
  endtask

  task automatic run_msg(input int n, input bit seq, input logic [31:0] base, input bit mask_len);
    make_msg(n, seq, base);
    push_expect(mask_len);
    drive_msg(1'b1);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
    chk({tag, "_blk_valid"}, bus.blk_valid, 1'b0);
    chk({tag, "_blk_data"},  bus.blk_data,  '0);
    chk({tag, "_blk_first"}, bus.blk_first, 1'b0);
    chk({tag, "_blk_final"}, bus.blk_final, 1'b0);
    chk({tag, "_err_len"},   bus.err_len,   1'b0);
  endtask

  // Consumer-side ready: random unless a stall is being forced
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.blk_ready = stall_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor, sampled mid-cycle while values are settled
  always @(negedge clk) begin
    if (reset_n && mon_en && bus.blk_valid) begin
      chk("in_ready_during_emit", bus.in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_block", 1'b1, 1'b0);
      end else begin
        chk("blk_data",  bus.blk_data & exp_q[0].mask, exp_q[0].data & exp_q[0].mask);
        chk("blk_first", bus.blk_first, exp_q[0].first);
        chk("blk_final", bus.blk_final, exp_q[0].fin);
        if (bus.blk_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #2 reset_n = 1'b0;
    #20;
    check_reset_outputs("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single word with latency check: PAD cycle then EMIT
    msg_q.delete();
    msg_q.push_back(32'h6162_6364);
    push_expect(1'b0);
    drive_msg(1'b1);
    chk("lat_pad_cycle", bus.blk_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_emit_cycle", bus.blk_valid, 1'b1);
    wait_drain();

    run_msg(20, 1'b1, 32'd0, 1'b0);
    run_msg(14, 1'b1, 32'h100, 1'b0);
    run_msg(16, 1'b1, 32'h200, 1'b0);
    run_msg(15, 1'b0, 32'd0, 1'b0);
    run_msg(13, 1'b0, 32'd0, 1'b0);

    // Forced stall during EMIT, then a back-to-back message
    stall_mode = 1'b1;
    make_msg(3, 1'b0, 32'd0);
    push_expect(1'b0);
    drive_msg(1'b1);
    begin
      int budget = 0;
      while (!bus.blk_valid && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_valid_held", bus.blk_valid, 1'b1);
    stall_mode = 1'b0;
    make_msg(5, 1'b0, 32'd0);
    push_expect(1'b0);
    drive_msg(1'b1);
    wait_drain();

    // Reset after 7 words discards the partial message
    make_msg(7, 1'b0, 32'd0);
    drive_msg(1'b0);
    chk("partial_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run_msg(1, 1'b0, 32'd0, 1'b0);

    for (int m = 0; m < 12; m++) begin
      run_msg($urandom_range(1, 40), 1'b0, 32'd0, 1'b0);
    end

    // Largest legal message, then one word too many
    run_msg(63, 1'b0, 32'd0, 1'b0);
    chk("err_len_at_max", bus.err_len, 1'b0);
    run_msg(64, 1'b0, 32'd0, 1'b1);
    chk("err_len_overflow", bus.err_len, 1'b1);
    run_msg(2, 1'b0, 32'd0, 1'b0);
    chk("err_len_sticky", bus.err_len, 1'b1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("err_len_reset", bus.err_len, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
